// File: rtl/dma_sched_pkg.sv
// dma_sched_pkg: shared state/source encodings and OAM target default for dma_scheduler
package dma_sched_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_HALT, ST_RUN} state_t;
  typedef enum logic [1:0] {SRC_CPU, SRC_OAM, SRC_PPU, SRC_DMC} src_t;
  localparam logic [15:0] PPU_OAM_ADDR_DEF = 16'h2004;
endpackage

// File: rtl/oam_byte_counter.sv
// oam_byte_counter: 8-bit OAM byte index with clear, increment and last-byte flag
module oam_byte_counter #(
  parameter int LEN = 256
) (
  input  logic       CLK,
  input  logic       RES,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] cnt,
  output logic       wrap
);
  assign wrap = cnt == 8'(LEN - 1);
  // clear on a new transfer, step after each OAM write, roll over after the last byte
  always_ff @(posedge CLK or posedge RES)
    if (RES) cnt <= 8'd0;
    else if (clr) cnt <= 8'd0;
    else if (inc) cnt <= wrap ? 8'd0 : cnt + 8'd1;
endmodule

// File: rtl/dma_scheduler.sv
// dma_scheduler: halts the core and interleaves OAM page copies with DMC sample fetches
import dma_sched_pkg::*;
module dma_scheduler #(
  parameter logic [15:0] PPU_OAM_ADDR = PPU_OAM_ADDR_DEF,
  parameter int          OAM_LEN      = 256
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        CYC,
  input  logic        GET,
  input  logic        RnW,
  input  logic        W4014,
  input  logic [7:0]  DB,
  input  logic        DMC_REQ,
  input  logic [15:0] DMC_Addr,
  input  logic [15:0] CPU_Addr,
  output logic [15:0] Addr,
  output logic        RD,
  output logic        WR,
  output logic        SPR_PPU,
  output logic        RDY,
  output logic        DMC_ACK,
  output logic        BUSY
);
  state_t     st;
  src_t       src;
  logic [7:0] page, cnt;
  logic       pend, held, wrap;
  logic       go_run, fin, start, dmc_rd, oam_rd, oam_wr, busy_n;
  oam_byte_counter #(.LEN(OAM_LEN)) u_cnt (
    .CLK(CLK),
    .RES(RES),
    .clr(CYC && st == ST_IDLE && W4014),
    .inc(CYC && oam_wr),
    .cnt(cnt),
    .wrap(wrap)
  );
  // decide the action of the CPU cycle that begins at this CYC; a halt ends once the core reads
  always_comb begin
    start  = st == ST_IDLE && (W4014 || DMC_REQ);
    go_run = st == ST_RUN || (st == ST_HALT && RnW);
    fin    = st == ST_RUN && !pend && !held && !DMC_REQ;
    dmc_rd = go_run && !fin && GET && DMC_REQ;
    oam_rd = go_run && !fin && GET && !DMC_REQ && pend && !held;
    oam_wr = go_run && !fin && !GET && held;
    busy_n = start || (st != ST_IDLE && !fin);
    Addr   = src == SRC_DMC ? DMC_Addr :
             src == SRC_OAM ? {page, cnt} :
             src == SRC_PPU ? PPU_OAM_ADDR : CPU_Addr;
  end
  // state, transfer bookkeeping and per-CPU-cycle registered outputs
  always_ff @(posedge CLK or posedge RES)
    if (RES) begin
      st      <= ST_IDLE;
      src     <= SRC_CPU;
      page    <= 8'd0;
      pend    <= 1'b0;
      held    <= 1'b0;
      RD      <= 1'b0;
      WR      <= 1'b0;
      SPR_PPU <= 1'b0;
      DMC_ACK <= 1'b0;
      RDY     <= 1'b1;
      BUSY    <= 1'b0;
    end else if (CYC) begin
      RD      <= dmc_rd || oam_rd;
      WR      <= oam_wr;
      SPR_PPU <= oam_wr;
      DMC_ACK <= dmc_rd;
      RDY     <= !busy_n;
      BUSY    <= busy_n;
      src     <= dmc_rd ? SRC_DMC : oam_rd ? SRC_OAM : oam_wr ? SRC_PPU : SRC_CPU;
      st      <= start ? ST_HALT : fin ? ST_IDLE : go_run ? ST_RUN : st;
      if (st == ST_IDLE && W4014) begin
        page <= DB;
        pend <= 1'b1;
      end
      if (oam_rd) held <= 1'b1;
      if (oam_wr) begin
        held <= 1'b0;
        if (wrap) pend <= 1'b0;
      end
    end
endmodule

// File: doc/dma_scheduler.md
DMA_SCHEDULER -- requirements
Module: dma_scheduler

Interface
REQ-001 Parameter PPU_OAM_ADDR, default 16'h2004, fixed OAM write target address.
REQ-002 Parameter OAM_LEN, default 256, bytes per OAM transfer; the count is 8 bits and wraps.
REQ-003 CLK  in  1  single clock.
REQ-004 RES  in  1  reset, asynchronous, active-high.
REQ-005 CYC  in  1  one-CLK strobe at each CPU-cycle boundary; state changes only on CLK edges with CYC=1.
REQ-006 GET  in  1  1: the CPU cycle beginning at this CYC is a get (ACLK1) cycle; 0: a put cycle.
REQ-007 RnW  in  1  core read/write for the current CPU cycle.
REQ-008 W4014  in  1  $4014 write strobe.
REQ-009 DB  in  8  data bus; holds the OAM source page while W4014=1.
REQ-010 DMC_REQ  in  1  DMC sample fetch request; a level held until DMC_ACK.
REQ-011 DMC_Addr  in  16  DMC fetch address.
REQ-012 CPU_Addr  in  16  core address.
REQ-013 Addr  out  16  external address bus.
REQ-014 RD  out  1  external read enable.
REQ-015 WR  out  1  external write enable.
REQ-016 SPR_PPU  out  1  OAM write to PPU_OAM_ADDR in progress.
REQ-017 RDY  out  1  0 halts the core.
REQ-018 DMC_ACK  out  1  one-CPU-cycle pulse marking the cycle DMC data is on DB.
REQ-019 BUSY  out  1  an OAM or DMC transfer is pending or active.

Function
REQ-020 RD, WR, SPR_PPU, RDY, DMC_ACK and BUSY are registered per CPU cycle. Addr is a combinational mux from the registered source select: CPU_Addr, {page,cnt}, PPU_OAM_ADDR or DMC_Addr.
REQ-021 W4014=1 at CYC in IDLE: latch DB as page, clear cnt, set oam_pend. W4014 is ignored while BUSY.
REQ-022 States: IDLE, HALT, RUN.
REQ-023 IDLE -> HALT at CYC when oam_pend or DMC_REQ is set. From that cycle RDY=0 and BUSY=1.
REQ-024 HALT: if RnW=1 during the cycle, -> RUN at its end. If RnW=0, stay in HALT (core writes are never stolen). Addr=CPU_Addr in IDLE and HALT.
REQ-025 RUN, GET=1 cycle:
- If DMC_REQ is set: DMC read (Addr=DMC_Addr, RD=1, DMC_ACK=1). DMC has priority.
- Else if oam_pend and no byte is held: OAM read (Addr={page,cnt}, RD=1), set held.
- Else: waste cycle.
REQ-026 RUN, GET=0 cycle:
- If held: OAM write (Addr=PPU_OAM_ADDR, WR=1, SPR_PPU=1), clear held, cnt+1.
- Else: waste cycle (RD=WR=0, Addr=CPU_Addr).
REQ-027 When the write of byte cnt=255 completes, cnt wraps to 0 and oam_pend clears.
REQ-028 RUN -> IDLE at the CYC where oam_pend=0, held=0 and DMC_REQ=0; RDY=1 and BUSY=0 from the next cycle.
REQ-029 A DMC_REQ rising during HALT or RUN is served on the next get cycle, with no additional halt cycle.
REQ-030 OAM-only transfer: 513 halted cycles when the cycle after HALT is a get cycle, otherwise 514. Each DMC steal inside an OAM transfer adds 2 cycles.
REQ-031 RD and WR are never both 1.

Reset
REQ-032 RES=1 forces IDLE immediately, regardless of CLK: RDY=1, RD=WR=SPR_PPU=DMC_ACK=BUSY=0, page=0, cnt=0, oam_pend=0, held=0, Addr=CPU_Addr.
REQ-033 Reset mid-transfer abandons the transfer. After reset release, the block waits for a new W4014 or DMC_REQ.

Structure
REQ-034 Package dma_sched_pkg holds the state enum, the address-source enum and the PPU_OAM_ADDR default.
REQ-035 Sub-module oam_byte_counter holds the 8-bit cnt with clear/increment and a wrap flag; the rest is the top-level FSM.

Verification
REQ-036 W4014 with DB=8'h02, first RUN cycle a get cycle -> reads $0200..$02FF alternating with writes to $2004, RDY low for exactly 513 cycles.
REQ-037 Same as REQ-036 but first RUN cycle a put cycle -> one waste cycle, RDY low for exactly 514 cycles, 256 WR pulses.
REQ-038 DMC_REQ with DMC_Addr=16'hC000 while idle -> HALT, then a read of $C000 on the first get cycle with DMC_ACK=1, then IDLE with RDY=1.
REQ-039 DMC_REQ asserted at OAM byte 16'h0280 -> DMC read of DMC_Addr on the next get cycle, OAM read of $0280 resumes 2 cycles later, total 515 or 516 cycles, OAM data intact.
REQ-040 RnW=0 for 3 cycles after W4014 -> HALT held for 3 cycles with no RD or WR, then a normal transfer.
REQ-041 RES pulse at byte 100 -> outputs reach reset values immediately; a new W4014 with DB=8'h03 restarts at $0300.
